// File: rtl/fp_pkg.sv
// Shared FP/int conversion definitions, common to fp2int_seq and int2fp.
// Holds the IEEE-754 single-precision field constants, the integer
// saturation limits and the sequencer state type.
package fp_pkg;

  localparam int FP_W      = 32;
  localparam int INT_W     = 32;
  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  localparam logic [INT_W-1:0]    INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0]    INT_MIN     = 32'h8000_0000;
  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fp_state_t;

endpackage

// File: rtl/fp2int_seq_if.sv
// Handshake bundle for fp2int_seq.
//   in_valid/in_ready/in_fp              : operand channel (producer -> converter)
//   out_valid/out_ready/out_int/flags    : result channel (converter -> consumer)
// master = producer/consumer side, slave = converter.
interface fp2int_seq_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  in_fp;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_int;
  logic             out_invalid;
  logic             out_inexact;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_int, out_invalid, out_inexact
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_int, out_invalid, out_inexact
  );

endinterface

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single-precision field splitter and classifier.
//   fp       : packed float {sign, exp[7:0], mant[22:0]}
//   sign     : sign bit
//   exp_unb  : unbiased exponent (exp - 127), signed
//   sig      : significand with the hidden bit ({exp!=0, mant})
//   is_zero / is_sub / is_inf / is_nan : operand class
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0]        fp,
  output logic                   sign,
  output logic signed [8:0]      exp_unb,
  output logic [FP_MANT_W:0]     sig,
  output logic                   is_zero,
  output logic                   is_sub,
  output logic                   is_inf,
  output logic                   is_nan
);

  logic [FP_EXP_W-1:0]  exp_raw;
  logic [FP_MANT_W-1:0] mant;
  logic                 exp_zero;
  logic                 exp_max;
  logic                 mant_nz;

  assign sign     = fp[FP_W-1];
  assign exp_raw  = fp[FP_W-2:FP_MANT_W];
  assign mant     = fp[FP_MANT_W-1:0];

  assign exp_zero = (exp_raw == '0);
  assign exp_max  = (exp_raw == EXP_SPECIAL);
  assign mant_nz  = (mant != '0);

  assign exp_unb  = $signed({1'b0, exp_raw}) - 9'sd127;
  assign sig      = {~exp_zero, mant};

  assign is_zero  = exp_zero & ~mant_nz;
  assign is_sub   = exp_zero &  mant_nz;
  assign is_inf   = exp_max  & ~mant_nz;
  assign is_nan   = exp_max  &  mant_nz;

endmodule

// File: rtl/fp2int_seq.sv
// Sequential float32 -> int32 converter, round toward zero, saturating.
// Special and out-of-range operands resolve on the accept edge; ordinary
// ones are aligned by an iterative shifter moving up to SHIFT_STEP bits
// per cycle, with a sticky bit collecting everything shifted out.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp2int_seq_if.slave (operand and result handshakes)
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for an operand
// ST_SHIFT | aligning the significand, cnt positions left to go
// ST_DONE  | out_valid high, result held until out_ready
module fp2int_seq
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 8
)
(
  input  logic         clk,
  input  logic         rst_n,
  fp2int_seq_if.slave  bus
);

  logic                 u_sign;
  logic signed [8:0]    u_exp;
  logic [FP_MANT_W:0]   u_sig;
  logic                 u_zero;
  logic                 u_sub;
  logic                 u_inf;
  logic                 u_nan;

  fp_unpack u_unpack (
    .fp      (bus.in_fp),
    .sign    (u_sign),
    .exp_unb (u_exp),
    .sig     (u_sig),
    .is_zero (u_zero),
    .is_sub  (u_sub),
    .is_inf  (u_inf),
    .is_nan  (u_nan)
  );

  fp_state_t         state;
  logic [INT_W-1:0]  work;
  logic [4:0]        cnt;
  logic              dir_left;
  logic              sign_q;
  logic              sticky;
  logic              ready_q;
  logic              valid_q;
  logic [INT_W-1:0]  int_q;
  logic              invalid_q;
  logic              inexact_q;

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_int     = int_q;
  assign bus.out_invalid = invalid_q;
  assign bus.out_inexact = inexact_q;

  // Accept-time decode: everything except the shift cases is final here.
  logic [INT_W-1:0] mag_full;
  logic [INT_W-1:0] dec_int;
  logic             dec_invalid;
  logic             dec_inexact;
  logic             dec_shift;
  logic             dec_left;
  logic [4:0]       dec_cnt;

  assign mag_full = {8'b0, u_sig};

  always_comb begin
    dec_int     = '0;
    dec_invalid = 1'b0;
    dec_inexact = 1'b0;
    dec_shift   = 1'b0;
    dec_left    = 1'b0;
    dec_cnt     = '0;
    if (u_inf || u_nan) begin
      dec_invalid = 1'b1;
      dec_int     = (u_nan || !u_sign) ? INT_MAX : INT_MIN;
    end else if (u_zero || u_sub) begin
      dec_inexact = u_sub;
    end else if (u_exp < 9'sd0) begin
      dec_inexact = 1'b1;
    end else if (u_exp >= 9'sd31) begin
      // -2^31 is the one E==31 value that is representable
      if (u_sign && (u_exp == 9'sd31) && (u_sig[FP_MANT_W-1:0] == '0)) begin
        dec_int = INT_MIN;
      end else begin
        dec_invalid = 1'b1;
        dec_int     = u_sign ? INT_MIN : INT_MAX;
      end
    end else if (u_exp == 9'sd23) begin
      dec_int = u_sign ? -mag_full : mag_full;
    end else begin
      dec_shift = 1'b1;
      dec_left  = (u_exp > 9'sd23);
      dec_cnt   = dec_left ? 5'(u_exp - 9'sd23) : 5'(9'sd23 - u_exp);
    end
  end

  // One shifter step: s = min(cnt, SHIFT_STEP).
  logic [4:0]       step;
  logic [INT_W-1:0] shifted;
  logic             lost;
  logic [4:0]       cnt_next;

  always_comb begin
    if (int'(cnt) < SHIFT_STEP) step = cnt;
    else                        step = 5'(SHIFT_STEP);
    shifted  = dir_left ? (work << step) : (work >> step);
    lost     = ~dir_left & (|(work & ((32'd1 << step) - 32'd1)));
    cnt_next = cnt - step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work      <= '0;
      cnt       <= '0;
      dir_left  <= 1'b0;
      sign_q    <= 1'b0;
      sticky    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      int_q     <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            ready_q   <= 1'b0;
            sign_q    <= u_sign;
            work      <= mag_full;
            cnt       <= dec_cnt;
            dir_left  <= dec_left;
            sticky    <= 1'b0;
            int_q     <= dec_int;
            invalid_q <= dec_invalid;
            inexact_q <= dec_inexact;
            if (dec_shift) begin
              state <= ST_SHIFT;
            end else begin
              state   <= ST_DONE;
              valid_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work   <= shifted;
          cnt    <= cnt_next;
          sticky <= sticky | lost;
          // final step publishes the result directly from the shifter output
          if (cnt_next == '0) begin
            int_q     <= sign_q ? -shifted : shifted;
            inexact_q <= sticky | lost;
            valid_q   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp2int_seq.sv
// Scoreboard bench for fp2int_seq: the driver pushes model results into a
// queue on each accept; the monitor pops and compares on each output,
// checking value, flags, latency, hold-under-backpressure and ready timing.
module tb_fp2int_seq;

  localparam int STEP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp2int_seq_if bus ();

  fp2int_seq #(.SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] val;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bp_hold  = 0;
  bit   active   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Value-level reference: the float is sig * 2^k, truncated toward zero,
  // then range-checked against the int32 limits.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   r;
    int     e;
    int     k;
    int     d;
    longint sig;
    longint mag;
    longint v;
    logic   inx;
    e     = int'(f[30:23]);
    sig   = longint'(f[22:0]);
    r.inv = 1'b0;
    r.inx = 1'b0;
    r.lat = 1;
    r.acc = 0;
    if (e == 255) begin
      r.inv = 1'b1;
      r.val = (sig != 0 || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      inx = 1'b0;
      if (e == 0) begin
        mag = 0;
        inx = (sig != 0);
      end else begin
        sig = sig + (longint'(1) << 23);
        k   = e - 150;
        if (k > 16)        mag = longint'(1) << 40;
        else if (k >= 0)   mag = sig << k;
        else if (k <= -24) begin mag = 0; inx = 1'b1; end
        else begin
          mag = sig >> (-k);
          inx = ((sig & ((longint'(1) << (-k)) - 1)) != 0);
        end
        if (e >= 127 && e <= 157 && e != 150) begin
          d     = (e > 150) ? e - 150 : 150 - e;
          r.lat = 1 + (d + STEP - 1) / STEP;
        end
      end
      v = f[31] ? -mag : mag;
      if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
        r.inv = 1'b1;
        r.val = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r.val = v[31:0];
        r.inx = inx;
      end
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] f);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.in_fp    = f;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", waited);
    end else begin
      e     = model(f);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || active) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || active) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: compares and drives out_ready.
  initial begin : monitor
    exp_t        e;
    logic [31:0] held_int;
    logic [1:0]  held_flags;
    int          hold;
    bit          hs_pend;
    hold    = 0;
    hs_pend = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active  = 0;
        hs_pend = 0;
        bus.out_ready = 1'b0;
      end else begin
        if (hs_pend) begin
          hs_pend = 0;
          active  = 0;
          bus.out_ready = 1'b0;
          check("ready_after_hs", {31'b0, bus.in_ready}, 32'd1);
          check("valid_after_hs", {31'b0, bus.out_valid}, 32'd0);
        end
        if (bus.out_valid) begin
          if (!active) begin
            active = 1;
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_output: out_int 0x%08h with empty scoreboard", bus.out_int);
            end else begin
              e = sb.pop_front();
              check("out_int", bus.out_int, e.val);
              check("flags_inv_inx", {30'b0, bus.out_invalid, bus.out_inexact}, {30'b0, e.inv, e.inx});
              check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
            held_int   = bus.out_int;
            held_flags = {bus.out_invalid, bus.out_inexact};
            hold       = bp_hold;
          end else begin
            check("hold_stable", {bus.out_int ^ held_int}, 32'd0);
            check("hold_flags", {30'b0, bus.out_invalid, bus.out_inexact}, {30'b0, held_flags});
          end
          check("busy_ready_low", {31'b0, bus.in_ready}, 32'd0);
          if (hold == 0) begin
            bus.out_ready = 1'b1;
            hs_pend = 1;
          end else begin
            hold--;
            bus.out_ready = 1'b0;
          end
        end
      end
    end
  end

  logic [31:0] dir_vec [12] = '{
    32'h4049_0FDB, 32'hC2F6_0000, 32'h4B00_0001, 32'h4F00_0000,
    32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h3F00_0000,
    32'h0000_0001, 32'h8000_0000, 32'h7F80_0000, 32'h4EFF_FFFF
  };

  initial begin : stim
    logic [31:0] f;
    bus.in_valid = 1'b0;
    bus.in_fp    = '0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_int", bus.out_int, 32'd0);
    check("rst_flags", {30'b0, bus.out_invalid, bus.out_inexact}, 32'd0);
    rst_n = 1'b1;

    // directed vectors, back to back so later operands wait behind SHIFT
    for (int i = 0; i < 12; i++) send(dir_vec[i]);
    drain();

    // long backpressure on a shift-path result
    bp_hold = 5;
    send(32'h4049_0FDB);
    drain();
    bp_hold = 0;

    // reset in the middle of SHIFT aborts the conversion
    send(32'h4049_0FDB);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("abort_out_int", bus.out_int, 32'd0);
    check("abort_flags", {30'b0, bus.out_invalid, bus.out_inexact}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(32'h4120_0000);
    drain();

    // random operands, mostly in the interesting exponent window
    for (int i = 0; i < 250; i++) begin
      f = $urandom;
      if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(100, 165));
      bp_hold = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(f);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
